// File: rtl/xbar_pkg.sv
// Shared types and constants for the two-master, two-slave crossbar.
// Used by the read-request arbiter and the round-robin helper.
package xbar_pkg;

   localparam int unsigned NUM_MASTERS = 2;
   localparam logic        CMD_READ    = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      REQ,
      LOG
   } rd_arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: the master that did not win last time is
// preferred when it is requesting, otherwise the other one is taken.
module rr_arbiter_2
   import xbar_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] request,
   input  logic                   last_grant,
   output logic                   grant,
   output logic                   valid
);

   always_comb begin
      valid = |request;
      grant = last_grant;
      if (request[~last_grant]) begin
         grant = ~last_grant;
      end
   end

endmodule

// File: rtl/rd_req_arbiter.sv
// Slave-side read-request arbiter: pops one master FIFO entry by round-robin,
// holds it on the slave req/addr/cmd interface until ack, then logs the winner.
module rd_req_arbiter
   import xbar_pkg::*;
#(
   parameter int unsigned AWIDTH = 32
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [NUM_MASTERS-1:0] fifo_empty,
   output logic [NUM_MASTERS-1:0] fifo_rden,
   input  logic [AWIDTH-1:0]      fifo_rdata0,
   input  logic [AWIDTH-1:0]      fifo_rdata1,
   output logic                   s_req,
   output logic [AWIDTH-1:0]      s_addr,
   output logic                   s_cmd,
   input  logic                   s_ack,
   input  logic                   rsp_id_full,
   output logic                   rsp_id_wren,
   output logic                   rsp_id
);

   rd_arb_state_e            state_q, state_d;
   logic                     grant_q, grant_d;
   logic                     last_grant_q, last_grant_d;
   logic [NUM_MASTERS-1:0]   fifo_rden_q, fifo_rden_d;
   logic                     s_req_q, s_req_d;
   logic [AWIDTH-1:0]        s_addr_q, s_addr_d;
   logic                     rsp_id_wren_q, rsp_id_wren_d;
   logic                     rsp_id_q, rsp_id_d;

   logic [NUM_MASTERS-1:0]   req_vec;
   logic                     arb_grant;
   logic                     arb_valid;

   assign req_vec = ~fifo_empty;

   rr_arbiter_2 u_rr (
      .request    (req_vec),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      fifo_rden_d   = '0;
      s_req_d       = s_req_q;
      s_addr_d      = s_addr_q;
      rsp_id_wren_d = 1'b0;
      rsp_id_d      = rsp_id_q;

      case (state_q)
         IDLE: begin
            // rden is registered here so the pop strobe lands in the POP cycle
            if (arb_valid && !rsp_id_full) begin
               grant_d                = arb_grant;
               last_grant_d           = arb_grant;
               fifo_rden_d[arb_grant] = 1'b1;
               state_d                = POP;
            end
         end
         POP: begin
            state_d = LOAD;
         end
         LOAD: begin
            s_addr_d = grant_q ? fifo_rdata1 : fifo_rdata0;
            rsp_id_d = grant_q;
            s_req_d  = 1'b1;
            state_d  = REQ;
         end
         REQ: begin
            if (s_ack) begin
               s_req_d       = 1'b0;
               rsp_id_wren_d = 1'b1;
               state_d       = LOG;
            end
         end
         LOG: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         fifo_rden_q   <= '0;
         s_req_q       <= 1'b0;
         s_addr_q      <= '0;
         rsp_id_wren_q <= 1'b0;
         rsp_id_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         fifo_rden_q   <= fifo_rden_d;
         s_req_q       <= s_req_d;
         s_addr_q      <= s_addr_d;
         rsp_id_wren_q <= rsp_id_wren_d;
         rsp_id_q      <= rsp_id_d;
      end
   end

   assign fifo_rden   = fifo_rden_q;
   assign s_req       = s_req_q;
   assign s_addr      = s_addr_q;
   assign s_cmd       = CMD_READ;
   assign rsp_id_wren = rsp_id_wren_q;
   assign rsp_id      = rsp_id_q;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Scoreboard bench for rd_req_arbiter: directed FIFO loads push expected
// transactions; a negedge monitor checks pops, slave accepts and id logging.
module tb_rd_req_arbiter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [1:0]  fifo_empty;
   logic [1:0]  fifo_rden;
   logic [31:0] fifo_rdata0;
   logic [31:0] fifo_rdata1;
   logic        s_req;
   logic [31:0] s_addr;
   logic        s_cmd;
   logic        s_ack;
   logic        rsp_id_full;
   logic        rsp_id_wren;
   logic        rsp_id;

   always #5 aclk = ~aclk;

   rd_req_arbiter #(.AWIDTH(32)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .fifo_empty  (fifo_empty),
      .fifo_rden   (fifo_rden),
      .fifo_rdata0 (fifo_rdata0),
      .fifo_rdata1 (fifo_rdata1),
      .s_req       (s_req),
      .s_addr      (s_addr),
      .s_cmd       (s_cmd),
      .s_ack       (s_ack),
      .rsp_id_full (rsp_id_full),
      .rsp_id_wren (rsp_id_wren),
      .rsp_id      (rsp_id)
   );

   // master-side FIFO models: tails written by stimulus, heads by the pop logic
   logic [31:0] mem0 [32];
   logic [31:0] mem1 [32];
   logic [4:0]  tail0, tail1, head0, head1;

   assign fifo_empty = {head1 == tail1, head0 == tail0};

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         head0       <= tail0;
         head1       <= tail1;
         fifo_rdata0 <= '0;
         fifo_rdata1 <= '0;
      end else begin
         if (fifo_rden[0]) begin
            fifo_rdata0 <= mem0[head0];
            head0       <= head0 + 5'd1;
         end
         if (fifo_rden[1]) begin
            fifo_rdata1 <= mem1[head1];
            head1       <= head1 + 5'd1;
         end
      end
   end

   // expected transaction list, in grant order
   logic [31:0] exp_addr [32];
   logic        exp_id   [32];
   int unsigned exp_wr;

   // slave responder controls
   int unsigned ack_delay;
   bit          ack_hold;
   bit          ack_en;
   bit          check_spacing;
   bit          drain_req;
   bit          drain_done;

   initial begin
      int unsigned cnt;
      s_ack = 1'b0;
      cnt   = 0;
      forever begin
         @(posedge aclk);
         #1;
         if (ack_hold) begin
            s_ack = 1'b1;
         end else if (s_ack) begin
            s_ack = 1'b0;
            cnt   = 0;
         end else if (s_req && ack_en) begin
            if (cnt == ack_delay) s_ack = 1'b1;
            else                  cnt++;
         end else begin
            cnt = 0;
         end
      end
   end

   // monitor / scoreboard
   int unsigned n_cmp, n_fail, cyc;
   int unsigned rden_rd, acc_rd, wren_rd;
   int unsigned drain_cnt, drop_cyc, last_wren;
   bit          prev_req, prev_full, drop_armed, have_wren;
   logic [31:0] prev_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0;
      rden_rd = 0; acc_rd = 0; wren_rd = 0;
      drain_cnt = 0; drop_cyc = 0; last_wren = 0;
      prev_req = 0; prev_full = 0; drop_armed = 0; have_wren = 0;
      prev_addr = '0; drain_done = 0;
      forever begin
         @(negedge aclk);
         cyc++;
         if (!aresetn) begin
            chk("reset_s_req", s_req, 0);
            chk("reset_fifo_rden", fifo_rden, 0);
            chk("reset_rsp_id_wren", rsp_id_wren, 0);
            chk("reset_s_addr", s_addr, 0);
            chk("reset_rsp_id", rsp_id, 0);
            chk("reset_s_cmd", s_cmd, 0);
            rden_rd = exp_wr; acc_rd = exp_wr; wren_rd = exp_wr;
            prev_req = 0; prev_full = 0; drop_armed = 0; have_wren = 0;
         end else begin
            if (prev_full && !rsp_id_full) begin
               drop_cyc   = cyc;
               drop_armed = 1;
            end
            if (prev_full && rsp_id_full) chk("rden_while_full", fifo_rden, 0);
            if (fifo_rden != 2'b00) begin
               if (drop_armed) begin
                  chk("rden_after_full_drop", cyc - drop_cyc, 1);
                  drop_armed = 0;
               end
               if (rden_rd == exp_wr) chk("rden_unexpected", fifo_rden, 0);
               else begin
                  chk("rden_onehot", fifo_rden, 64'd1 << exp_id[rden_rd % 32]);
                  rden_rd++;
               end
            end
            if (s_req && prev_req) begin
               chk("hold_s_addr", s_addr, prev_addr);
               chk("hold_no_rden", fifo_rden, 0);
            end
            if (s_req && s_ack) begin
               if (acc_rd == exp_wr) chk("accept_unexpected", s_addr, 64'hDEAD);
               else begin
                  chk("s_addr", s_addr, exp_addr[acc_rd % 32]);
                  chk("s_cmd", s_cmd, 0);
                  chk("rsp_id_at_req", rsp_id, exp_id[acc_rd % 32]);
                  acc_rd++;
               end
            end
            if (rsp_id_wren) begin
               if (wren_rd == acc_rd) chk("wren_unexpected", rsp_id_wren, 0);
               else begin
                  chk("rsp_id_log", rsp_id, exp_id[wren_rd % 32]);
                  wren_rd++;
               end
               if (check_spacing) begin
                  if (have_wren) chk("wren_spacing", cyc - last_wren, 5);
                  last_wren = cyc;
                  have_wren = 1;
               end
            end
            if (!check_spacing) have_wren = 0;
            prev_req  = s_req;
            prev_addr = s_addr;
            prev_full = rsp_id_full;
         end
         if (drain_req) begin
            if (!drain_done) begin
               if (wren_rd == exp_wr && !s_req) begin
                  drain_done = 1;
               end else if (++drain_cnt > 300) begin
                  chk("drain_timeout_pending", exp_wr - wren_rd, 0);
                  rden_rd = exp_wr; acc_rd = exp_wr; wren_rd = exp_wr;
                  drain_done = 1;
               end
            end
         end else begin
            drain_done = 0;
            drain_cnt  = 0;
         end
      end
   end

   task automatic load_fifo(input int m, input logic [31:0] a);
      if (m == 0) begin mem0[tail0] = a; tail0 = tail0 + 5'd1; end
      else        begin mem1[tail1] = a; tail1 = tail1 + 5'd1; end
   endtask

   task automatic expect_txn(input logic id, input logic [31:0] a);
      exp_id[exp_wr % 32]   = id;
      exp_addr[exp_wr % 32] = a;
      exp_wr++;
   endtask

   task automatic drain();
      drain_req = 1;
      wait (drain_done);
      drain_req = 0;
      wait (!drain_done);
      repeat (3) @(posedge aclk);
      #1;
   endtask

   initial begin
      repeat (20000) @(posedge aclk);
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b1; rsp_id_full = 1'b0;
      tail0 = '0; tail1 = '0; exp_wr = 0;
      ack_delay = 0; ack_hold = 0; ack_en = 1; check_spacing = 0; drain_req = 0;
      #2 aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;

      // single request from master 1, ack two cycles after s_req
      ack_delay = 2;
      load_fifo(1, 32'h8000_0010);
      expect_txn(1'b1, 32'h8000_0010);
      drain();

      // fairness: both FIFOs preloaded, last winner was master 1
      ack_delay = 0;
      load_fifo(0, 32'h0000_00A0); load_fifo(0, 32'h0000_00A4); load_fifo(0, 32'h0000_00A8);
      load_fifo(1, 32'h8000_00B0); load_fifo(1, 32'h8000_00B4); load_fifo(1, 32'h8000_00B8);
      expect_txn(1'b0, 32'h0000_00A0); expect_txn(1'b1, 32'h8000_00B0);
      expect_txn(1'b0, 32'h0000_00A4); expect_txn(1'b1, 32'h8000_00B4);
      expect_txn(1'b0, 32'h0000_00A8); expect_txn(1'b1, 32'h8000_00B8);
      drain();

      // ack stall of 20 cycles with the other FIFO waiting
      ack_delay = 20;
      load_fifo(0, 32'h0000_0C00); load_fifo(1, 32'h8000_0C04);
      expect_txn(1'b0, 32'h0000_0C00); expect_txn(1'b1, 32'h8000_0C04);
      drain();

      // routing FIFO full blocks grants until it drops
      ack_delay = 1;
      rsp_id_full = 1'b1;
      @(posedge aclk); #1;
      load_fifo(0, 32'h0000_0D00); load_fifo(1, 32'h8000_0D04);
      expect_txn(1'b0, 32'h0000_0D00); expect_txn(1'b1, 32'h8000_0D04);
      repeat (10) @(posedge aclk);
      #1 rsp_id_full = 1'b0;
      drain();

      // ack held high: one accept per REQ entry, 5-cycle spacing
      check_spacing = 1;
      ack_hold = 1;
      @(posedge aclk); #1;
      load_fifo(0, 32'h0000_0E00); load_fifo(1, 32'h8000_0E04);
      expect_txn(1'b0, 32'h0000_0E00); expect_txn(1'b1, 32'h8000_0E04);
      drain();
      ack_hold = 0;
      check_spacing = 0;
      repeat (2) @(posedge aclk);
      #1;

      // reset while in REQ, then master 0 must win first again
      ack_en = 0;
      ack_delay = 0;
      load_fifo(0, 32'h0000_0F00); load_fifo(1, 32'h8000_0F04);
      expect_txn(1'b0, 32'h0000_0F00); expect_txn(1'b1, 32'h8000_0F04);
      for (int i = 0; i < 20 && !s_req; i++) @(negedge aclk);
      @(posedge aclk);
      #1 aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      ack_en = 1;
      @(posedge aclk); #1;
      load_fifo(0, 32'h0000_0F10); load_fifo(1, 32'h8000_0F14);
      expect_txn(1'b0, 32'h0000_0F10); expect_txn(1'b1, 32'h8000_0F14);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
